// File: rtl/icache_ro_if.sv
// Fetch-port and instruction-memory-port signals of the read-only instruction cache.
// The cache takes the slave modport; the fetch stage and memory side take master.
interface icache_ro_if;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  modport slave (
    input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    output proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    input  proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/icache_ro.sv
// Direct-mapped read-only instruction cache: same-cycle hits, 4-word block refill
// on a miss with the fetch port stalled until memory answers.
module icache_ro #(
  parameter int NUM_BLOCKS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  icache_ro_if.slave bus
);
  localparam int IDX  = $clog2(NUM_BLOCKS);
  localparam int TAGW = 28 - IDX;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t                state;
  logic [NUM_BLOCKS-1:0] valid;
  logic [TAGW-1:0]       tags  [NUM_BLOCKS];
  logic [127:0]          lines [NUM_BLOCKS];

  logic [IDX-1:0]  idx;
  logic [TAGW-1:0] tag;
  logic [1:0]      offset;
  logic [127:0]    line_data;
  logic            hit;
  logic            fill;

  assign offset    = bus.proc_addr[1:0];
  assign idx       = bus.proc_addr[IDX+1:2];
  assign tag       = bus.proc_addr[29:IDX+2];
  assign line_data = lines[idx];
  assign hit       = bus.proc_read && valid[idx] && (tags[idx] == tag);
  assign fill      = (state == FETCH) && bus.mem_ready;

  assign bus.proc_rdata = line_data[{offset, 5'd0} +: 32];
  assign bus.proc_stall = (state == FETCH) || (bus.proc_read && !hit);
  assign bus.mem_addr   = bus.proc_addr[29:2];
  assign bus.mem_write  = 1'b0;
  assign bus.mem_wdata  = '0;

  // Write data never reaches the array; the cache has no store path.
  wire unused_write_path = &{1'b0, bus.proc_write, bus.proc_wdata};

  // Control FSM; an async reset clears state so an in-flight refill cannot land.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      valid        <= '0;
      bus.mem_read <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.proc_read && !hit) begin
            state        <= FETCH;
            bus.mem_read <= 1'b1;
          end
        end
        FETCH: begin
          if (bus.mem_ready) begin
            valid[idx]   <= 1'b1;
            state        <= IDLE;
            bus.mem_read <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          bus.mem_read <= 1'b0;
        end
      endcase
    end
  end

  // Tag and data arrays are plain storage; the valid bits alone make them meaningful.
  always_ff @(posedge clk) begin
    if (fill) begin
      tags[idx]  <= tag;
      lines[idx] <= bus.mem_rdata;
    end
  end
endmodule

// File: tb/tb_icache_ro.sv
// Self-checking bench for icache_ro: a memory model answers refills and a
// scoreboard queue holds the word each read is required to return.
module tb_icache_ro;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int passes = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  icache_ro_if bus();

  icache_ro #(.NUM_BLOCKS(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Block 1 holds 0x00000000..0x33333333; other blocks get distinct offsets.
  function automatic logic [31:0] mem_word(input logic [27:0] ba, input logic [1:0] w);
    logic [31:0] base;
    logic [31:0] delta;
    base  = 32'h11111111 * {30'd0, w};
    delta = {4'd0, ba - 28'd1} << 20;
    return base + delta;
  endfunction

  function automatic logic [127:0] block_of(input logic [27:0] ba);
    logic [127:0] blk;
    for (int w = 0; w < 4; w++) blk[32*w +: 32] = mem_word(ba, w[1:0]);
    return blk;
  endfunction

  task automatic do_read(input logic [29:0] addr, input bit expect_miss, input int lat,
                         input bit wr, input string name);
    int stall_cycles;
    int fetch_cycles;
    logic [31:0] exp;
    @(negedge clk);
    bus.proc_addr  = addr;
    bus.proc_read  = 1'b1;
    bus.proc_write = wr;
    exp_q.push_back(mem_word(addr[29:2], addr[1:0]));
    #1;
    checks++;
    if (bus.proc_stall !== expect_miss)
      $display("[TB] FAIL %s stall0: got %b expected %b", name, bus.proc_stall, expect_miss);
    else passes++;
    stall_cycles = (bus.proc_stall === 1'b1) ? 1 : 0;
    fetch_cycles = 0;
    while (bus.proc_stall === 1'b1 && stall_cycles < 40) begin
      @(negedge clk);
      bus.mem_ready = 1'b0;
      #1;
      if (bus.proc_stall !== 1'b1) break;
      stall_cycles++;
      if (stall_cycles == 2) begin
        checks++;
        if (bus.mem_read !== 1'b1)
          $display("[TB] FAIL %s mem_read: got %b expected 1", name, bus.mem_read);
        else passes++;
        checks++;
        if (bus.mem_addr !== addr[29:2])
          $display("[TB] FAIL %s mem_addr: got %h expected %h", name, bus.mem_addr, addr[29:2]);
        else passes++;
      end
      if (bus.mem_read === 1'b1) begin
        fetch_cycles++;
        if (fetch_cycles == lat) begin
          bus.mem_rdata = block_of(addr[29:2]);
          bus.mem_ready = 1'b1;
        end
      end
    end
    if (expect_miss) begin
      checks++;
      if (stall_cycles !== lat + 1)
        $display("[TB] FAIL %s stall_len: got %0d expected %0d", name, stall_cycles, lat + 1);
      else passes++;
    end
    exp = exp_q.pop_front();
    checks++;
    if (bus.proc_rdata !== exp)
      $display("[TB] FAIL %s rdata: got %h expected %h", name, bus.proc_rdata, exp);
    else passes++;
  endtask

  task automatic check_quiet(input string name);
    checks++;
    if (bus.proc_stall !== 1'b0)
      $display("[TB] FAIL %s stall: got %b expected 0", name, bus.proc_stall);
    else passes++;
    checks++;
    if (bus.mem_read !== 1'b0)
      $display("[TB] FAIL %s mem_read: got %b expected 0", name, bus.mem_read);
    else passes++;
    checks++;
    if (bus.mem_write !== 1'b0)
      $display("[TB] FAIL %s mem_write: got %b expected 0", name, bus.mem_write);
    else passes++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    check_quiet("reset_idle");
    checks++;
    if (bus.mem_wdata !== 128'd0)
      $display("[TB] FAIL reset_wdata: got %h expected 0", bus.mem_wdata);
    else passes++;
    bus.proc_addr = 30'h5;
    bus.proc_read = 1'b1;
    #1;
    checks++;
    if (bus.proc_stall !== 1'b1)
      $display("[TB] FAIL reset_stall_read: got %b expected 1", bus.proc_stall);
    else passes++;
    checks++;
    if (bus.mem_read !== 1'b0)
      $display("[TB] FAIL reset_mem_read: got %b expected 0", bus.mem_read);
    else passes++;
    repeat (2) @(negedge clk);
    bus.proc_read = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_cold_miss();
    do_read(30'h5, 1'b1, 3, 1'b0, "cold_miss_5");
  endtask

  task automatic test_hits();
    do_read(30'h4, 1'b0, 0, 1'b0, "hit_4");
    do_read(30'h7, 1'b0, 0, 1'b0, "hit_7");
    do_read(30'h5, 1'b0, 0, 1'b0, "hit_5");
  endtask

  task automatic test_idle_write();
    @(negedge clk);
    bus.proc_read  = 1'b0;
    bus.proc_write = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      check_quiet("idle");
    end
    bus.proc_write = 1'b1;
    bus.proc_addr  = 30'h3C;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check_quiet("write_only");
    end
    do_read(30'h6, 1'b0, 0, 1'b1, "write_read_hit_6");
    bus.proc_write = 1'b0;
  endtask

  task automatic test_spurious_ready();
    @(negedge clk);
    bus.proc_read = 1'b0;
    bus.proc_addr = 30'h7;
    bus.mem_rdata = {4{32'hFFFF_FFFF}};
    bus.mem_ready = 1'b1;
    @(negedge clk);
    bus.proc_read = 1'b1;
    #1;
    checks++;
    if (bus.mem_read !== 1'b0)
      $display("[TB] FAIL spurious_mem_read: got %b expected 0", bus.mem_read);
    else passes++;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    do_read(30'h7, 1'b0, 0, 1'b0, "spurious_hit_7");
  endtask

  task automatic test_conflict();
    do_read(30'h24, 1'b1, 2, 1'b0, "conflict_24");
    do_read(30'h4, 1'b1, 1, 1'b0, "evicted_4");
    do_read(30'h24, 1'b1, 5, 1'b0, "reevicted_24");
  endtask

  task automatic test_back_to_back();
    do_read(30'h80, 1'b1, 1, 1'b0, "b2b_miss_80");
    do_read(30'h101, 1'b1, 4, 1'b0, "b2b_miss_101");
    do_read(30'h102, 1'b0, 0, 1'b0, "b2b_hit_102");
    do_read(30'h25, 1'b0, 0, 1'b0, "b2b_hit_25");
  endtask

  task automatic test_reset_mid_fetch();
    @(negedge clk);
    bus.proc_addr = 30'h40;
    bus.proc_read = 1'b1;
    #1;
    checks++;
    if (bus.proc_stall !== 1'b1)
      $display("[TB] FAIL midfetch_stall: got %b expected 1", bus.proc_stall);
    else passes++;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bus.mem_read !== 1'b1)
      $display("[TB] FAIL midfetch_mem_read: got %b expected 1", bus.mem_read);
    else passes++;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.mem_read !== 1'b0)
      $display("[TB] FAIL midfetch_async_drop: got %b expected 0", bus.mem_read);
    else passes++;
    bus.mem_rdata = {4{32'hDEAD_BEEF}};
    bus.mem_ready = 1'b1;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    bus.proc_read = 1'b0;
    rst_n = 1'b1;
    do_read(30'h40, 1'b1, 2, 1'b0, "midfetch_refetch_40");
    do_read(30'h5, 1'b1, 1, 1'b0, "after_reset_5");
  endtask

  initial begin
    bus.proc_read  = 1'b0;
    bus.proc_write = 1'b0;
    bus.proc_addr  = '0;
    bus.proc_wdata = 32'hCAFE_F00D;
    bus.mem_rdata  = '0;
    bus.mem_ready  = 1'b0;
    test_reset();
    test_cold_miss();
    test_hits();
    test_idle_write();
    test_spurious_ready();
    test_conflict();
    test_back_to_back();
    test_reset_mid_fetch();
    @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
